ct_ifu_lbuf_ctrl: RTL and testbench

CT_IFU_LBUF_CTRL -- requirements
Module: ct_ifu_lbuf_ctrl

---
 rtl/ct_ifu_lbuf_pkg.sv | 24 ++
 rtl/ct_ifu_lbuf_ctrl_if.sv | 36 +++
 rtl/ct_ifu_lbuf_ctrl.sv | 119 +++++++++++
 tb/tb_ct_ifu_lbuf_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_lbuf_pkg.sv
// rtl/ct_ifu_lbuf_pkg.sv - shared loop buffer state enum, depth and pointer constants
// Contents:
//   LBUF_DEPTH  number of halfword entries sequenced by the controller
//   PTR_W       width of a binary entry index
//   lbuf_state_e  IDLE / FILL / ACTIVE state encoding (2'b11 unused)
//   lbuf_onehot  binary index to one-hot entry select
package ct_ifu_lbuf_pkg;

    localparam int LBUF_DEPTH = 16;
    localparam int PTR_W      = $clog2(LBUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FILL   = 2'b01,
        S_ACTIVE = 2'b10
    } lbuf_state_e;

    function automatic logic [LBUF_DEPTH-1:0] lbuf_onehot(input logic [PTR_W-1:0] idx);
        logic [LBUF_DEPTH-1:0] one;
        one = {{(LBUF_DEPTH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/ct_ifu_lbuf_ctrl_if.sv
// rtl/ct_ifu_lbuf_ctrl_if.sv - loop buffer controller handshake bundle
// Signals:
//   lbuf_flush, lbuf_start            pipeline control into the controller
//   fill_push, fill_back_br           capture-side halfword offer
//   rd_pop, loop_taken                consumer-side read and branch resolution
//   entry_create_x, fill_state_enter  entry write select / entry valid clear
//   lbuf_state, lbuf_active           controller status
//   rd_ptr, loop_cnt                  read select and completed-iteration count
// Modports: master = pipeline/testbench side, slave = controller side.
interface ct_ifu_lbuf_ctrl_if;
    import ct_ifu_lbuf_pkg::*;

    logic                  lbuf_flush;
    logic                  lbuf_start;
    logic                  fill_push;
    logic                  fill_back_br;
    logic                  rd_pop;
    logic                  loop_taken;
    logic [LBUF_DEPTH-1:0] entry_create_x;
    logic                  fill_state_enter;
    logic [1:0]            lbuf_state;
    logic                  lbuf_active;
    logic [LBUF_DEPTH-1:0] rd_ptr;
    logic [7:0]            loop_cnt;

    modport master (
        output lbuf_flush, lbuf_start, fill_push, fill_back_br, rd_pop, loop_taken,
        input  entry_create_x, fill_state_enter, lbuf_state, lbuf_active, rd_ptr, loop_cnt
    );

    modport slave (
        input  lbuf_flush, lbuf_start, fill_push, fill_back_br, rd_pop, loop_taken,
        output entry_create_x, fill_state_enter, lbuf_state, lbuf_active, rd_ptr, loop_cnt
    );

endinterface

// File: rtl/ct_ifu_lbuf_ctrl.sv
// rtl/ct_ifu_lbuf_ctrl.sv - loop buffer fill/replay sequencer
// Ports:
//   lbuf_vld_update_clk  clock for all state
//   cpurst_b             asynchronous active-low reset
//   lbuf_bus             ct_ifu_lbuf_ctrl_if.slave (see interface file for signals)
// Optional feature: define LBUF_LOOP_CNT_EN to implement the loop_cnt
// iteration counter; otherwise loop_cnt is tied to zero with no flops.
// The entry instances live in the parent; this block only produces their
// one-hot write select and the valid-clear pulse.
module ct_ifu_lbuf_ctrl #(
    parameter int LBUF_DEPTH = ct_ifu_lbuf_pkg::LBUF_DEPTH
) (
    input  logic                 lbuf_vld_update_clk,
    input  logic                 cpurst_b,
    ct_ifu_lbuf_ctrl_if.slave    lbuf_bus
);
    import ct_ifu_lbuf_pkg::*;

    lbuf_state_e            state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       br_ptr;
    logic [LBUF_DEPTH-1:0]  rd_ptr_q;
    logic                   active_q;
    logic                   rd_at_br;
    logic                   fill_enter;

    // Flush suppresses every same-cycle side effect, not just the transition.
    assign fill_enter = (state == S_IDLE) && lbuf_bus.lbuf_start && !lbuf_bus.lbuf_flush;
    assign rd_at_br   = (rd_ptr_q == lbuf_onehot(br_ptr));

    always_comb begin
        lbuf_bus.entry_create_x = '0;
        if ((state == S_FILL) && lbuf_bus.fill_push && !lbuf_bus.lbuf_flush) begin
            lbuf_bus.entry_create_x = lbuf_onehot(wr_ptr);
        end
    end

    assign lbuf_bus.fill_state_enter = fill_enter;
    assign lbuf_bus.lbuf_state       = state;
    assign lbuf_bus.lbuf_active      = active_q;
    assign lbuf_bus.rd_ptr           = rd_ptr_q;

    always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            br_ptr   <= '0;
            rd_ptr_q <= lbuf_onehot('0);
            active_q <= 1'b0;
        end else if (lbuf_bus.lbuf_flush) begin
            state    <= S_IDLE;
            active_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lbuf_bus.lbuf_start) begin
                        state  <= S_FILL;
                        wr_ptr <= '0;
                    end
                end
                S_FILL: begin
                    if (lbuf_bus.fill_push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (lbuf_bus.fill_back_br) begin
                            state    <= S_ACTIVE;
                            br_ptr   <= wr_ptr;
                            rd_ptr_q <= lbuf_onehot('0);
                            active_q <= 1'b1;
                        end else if (wr_ptr == PTR_W'(LBUF_DEPTH - 1)) begin
                            // Buffer full without seeing the back branch: loop too long.
                            state <= S_IDLE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (lbuf_bus.rd_pop) begin
                        if (rd_at_br) begin
                            if (lbuf_bus.loop_taken) begin
                                rd_ptr_q <= lbuf_onehot('0);
                            end else begin
                                state    <= S_IDLE;
                                active_q <= 1'b0;
                            end
                        end else begin
                            rd_ptr_q <= {rd_ptr_q[LBUF_DEPTH-2:0], rd_ptr_q[LBUF_DEPTH-1]};
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBUF_LOOP_CNT_EN
    logic [7:0] loop_cnt_q;
    logic       loop_wrap;

    assign loop_wrap = (state == S_ACTIVE) && !lbuf_bus.lbuf_flush && lbuf_bus.rd_pop
                       && rd_at_br && lbuf_bus.loop_taken;

    always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            loop_cnt_q <= 8'h00;
        end else if (fill_enter) begin
            loop_cnt_q <= 8'h00;
        end else if (loop_wrap && (loop_cnt_q != 8'hFF)) begin
            loop_cnt_q <= loop_cnt_q + 8'd1;
        end
    end

    assign lbuf_bus.loop_cnt = loop_cnt_q;
`else
    assign lbuf_bus.loop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ct_ifu_lbuf_ctrl.sv
// tb/tb_ct_ifu_lbuf_ctrl.sv - self-checking bench for ct_ifu_lbuf_ctrl
module tb_ct_ifu_lbuf_ctrl;

    logic clk = 1'b0;
    logic rstb;

    always #5 clk = ~clk;

    ct_ifu_lbuf_ctrl_if bus ();

    ct_ifu_lbuf_ctrl dut (
        .lbuf_vld_update_clk (clk),
        .cpurst_b            (rstb),
        .lbuf_bus            (bus)
    );

    localparam int M_IDLE   = 0;
    localparam int M_FILL   = 1;
    localparam int M_ACTIVE = 2;

    // Reference: captured-entry count, branch index, read index, iterations.
    int mode;
    int m_wr;
    int m_br;
    int m_rd;
    int m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef LBUF_LOOP_CNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        mode  = M_IDLE;
        m_wr  = 0;
        m_br  = 0;
        m_rd  = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit fl, input bit st, input bit pu, input bit bb,
                              input bit po, input bit tk);
        if (fl) begin
            mode = M_IDLE;
        end else if (mode == M_IDLE) begin
            if (st) begin
                mode  = M_FILL;
                m_wr  = 0;
                m_cnt = 0;
            end
        end else if (mode == M_FILL) begin
            if (pu) begin
                if (bb) begin
                    mode = M_ACTIVE;
                    m_br = m_wr;
                    m_rd = 0;
                end else if (m_wr == 15) begin
                    mode = M_IDLE;
                end
                m_wr = (m_wr + 1) % 16;
            end
        end else begin
            if (po) begin
                if (m_rd == m_br) begin
                    if (tk) begin
                        m_rd  = 0;
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    end else begin
                        mode = M_IDLE;
                    end
                end else begin
                    m_rd = m_rd + 1;
                end
            end
        end
    endtask

    task automatic chk_status(input string when);
        chk({when, " lbuf_state"},  32'(bus.lbuf_state), 32'(mode));
        chk({when, " lbuf_active"}, 32'(bus.lbuf_active), (mode == M_ACTIVE) ? 32'd1 : 32'd0);
        chk({when, " rd_ptr"},      32'(bus.rd_ptr), 32'd1 << m_rd);
        chk({when, " loop_cnt"},    32'(bus.loop_cnt), exp_cnt());
    endtask

    task automatic cycle(input bit fl, input bit st, input bit pu, input bit bb,
                         input bit po, input bit tk);
        bus.lbuf_flush   = fl;
        bus.lbuf_start   = st;
        bus.fill_push    = pu;
        bus.fill_back_br = bb;
        bus.rd_pop       = po;
        bus.loop_taken   = tk;
        #1;
        chk("fill_state_enter", 32'(bus.fill_state_enter),
            (mode == M_IDLE && st && !fl) ? 32'd1 : 32'd0);
        chk("entry_create_x", 32'(bus.entry_create_x),
            (mode == M_FILL && pu && !fl) ? (32'd1 << m_wr) : 32'd0);
        @(posedge clk);
        #1;
        model_step(fl, st, pu, bb, po, tk);
        chk_status("post-edge");
    endtask

    initial begin
        rstb = 1'b0;
        bus.lbuf_flush = 1'b0; bus.lbuf_start = 1'b0; bus.fill_push = 1'b0;
        bus.fill_back_br = 1'b0; bus.rd_pop = 1'b0; bus.loop_taken = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset entry_create_x", 32'(bus.entry_create_x), 32'd0);
        chk("reset fill_state_enter", 32'(bus.fill_state_enter), 32'd0);
        chk_status("reset");
        rstb = 1'b1;

        // Capture start: one-cycle clear pulse, then FILL.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Four-halfword loop, back branch in entry 3.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, (i == 3), 0, 0);

        // Three taken iterations.
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, (i == 3));

        // Not-taken exit, then a fresh start clears the count.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 0);

        // Sixteen pushes with no back branch: full abort.
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);

        // Flush on the back-branch push.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0, 0);

        // Reset in the middle of FILL with a push pending.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        bus.fill_push = 1'b1;
        rstb = 1'b0;
        #1;
        model_reset();
        chk("midreset entry_create_x", 32'(bus.entry_create_x), 32'd0);
        chk_status("midreset");
        @(posedge clk);
        #1;
        chk("midreset held entry_create_x", 32'(bus.entry_create_x), 32'd0);
        rstb = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);

        // Randomized traffic biased toward short loops.
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 4) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
